// File: rtl/sound_pkg.sv
// Shared definitions for the sound mixer: FSM states, register offsets, default sizing.
`timescale 1ns/1ps
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SAT,
    ST_OUT
  } state_t;

  localparam int unsigned LATCH_OFS = 0;
  localparam int unsigned MASK_OFS  = 1;
  localparam int unsigned GAIN_OFS  = 2;

  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_CH_W      = 4;
  localparam int unsigned DEF_OUT_W     = 12;
  localparam logic [15:0] DEF_BASE_ADDR = 16'h1840;

endpackage

// File: rtl/sound_mixer_regs.sv
// CPU register window of the sound mixer: output latch, mute mask and per-channel gains.
`timescale 1ns/1ps
module sound_mixer_regs
  import sound_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_3MHz_en,
  input  logic                wr_en,
  input  logic [15:0]         addr,
  input  logic [7:0]          wdata,
  output logic [7:0]          latch,
  output logic [7:0]          mask,
  output logic [NUM_CH*8-1:0] gains,
  output logic                mask_wr
);

  logic [15:0] ofs;
  logic        wr;

  assign ofs     = addr - BASE_ADDR;
  assign wr      = wr_en && clk_3MHz_en;
  assign mask_wr = wr && (ofs == 16'(MASK_OFS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latch <= '0;
      mask  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) gains[i*8 +: 8] <= 8'h01;
    end else if (wr) begin
      if (ofs == 16'(LATCH_OFS)) latch <= wdata;
      if (mask_wr) mask <= wdata;
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (ofs == 16'(GAIN_OFS + i)) gains[i*8 +: 8] <= wdata;
    end
  end

endmodule

// File: rtl/sound_mixer.sv
// Multi-channel gain/mute mixer with saturation; optional one-pole low-pass output
// filter enabled by defining SOUND_MIXER_LPF_EN.
`timescale 1ns/1ps
module sound_mixer
  import sound_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned CH_W      = DEF_CH_W,
  parameter int unsigned OUT_W     = DEF_OUT_W,
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_3MHz_en,
  input  logic                   sample_en,
  input  logic                   wr_en,
  input  logic [15:0]            addr,
  input  logic [7:0]             wdata,
  input  logic [NUM_CH*CH_W-1:0] ch_audio,
  output logic [7:0]             latch_out,
  output logic [OUT_W-1:0]       audio,
  output logic                   audio_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned ACC_W = CH_W + 8 + $clog2(NUM_CH);
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [CMP_W-1:0] OUT_MAX = (CMP_W'(1) << OUT_W) - CMP_W'(1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         term;
  logic [CMP_W-1:0]         acc_ext;
  logic [NUM_CH*CH_W-1:0]   snap;
  logic [OUT_W-1:0]         result;
  logic [OUT_W-1:0]         out_next;
  logic [7:0]               latch;
  logic [7:0]               mask;
  logic [NUM_CH*8-1:0]      gains;
  logic                     mask_wr;

  sound_mixer_regs #(
    .NUM_CH    (NUM_CH),
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .clk_3MHz_en (clk_3MHz_en),
    .wr_en       (wr_en),
    .addr        (addr),
    .wdata       (wdata),
    .latch       (latch),
    .mask        (mask),
    .gains       (gains),
    .mask_wr     (mask_wr)
  );

  assign latch_out = latch;
  assign busy      = (state != ST_IDLE);
  assign acc_ext   = CMP_W'(acc);

  // Gains and mask are read live, so CPU writes reach channels not yet accumulated.
  always_comb begin
    term = '0;
    if (!mask[idx])
      term = ACC_W'(snap[idx*CH_W +: CH_W]) * ACC_W'(gains[idx*8 +: 8]);
  end

`ifdef SOUND_MIXER_LPF_EN
  logic [OUT_W-1:0]        lpf_x;
  logic signed [OUT_W:0]   lpf_diff;
  logic signed [OUT_W:0]   lpf_step;

  // audio doubles as the filter state y; the true sum always fits in OUT_W bits.
  always_comb begin
    lpf_x    = latch[7] ? '0 : result;
    lpf_diff = $signed({1'b0, lpf_x}) - $signed({1'b0, audio});
    lpf_step = lpf_diff >>> 2;
    out_next = audio + lpf_step[OUT_W-1:0];
  end
`else
  always_comb begin
    out_next = latch[7] ? '0 : result;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      acc         <= '0;
      snap        <= '0;
      result      <= '0;
      audio       <= '0;
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      if (sample_en && state != ST_IDLE) overrun <= 1'b1;
      else if (mask_wr)                  overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (sample_en) begin
            snap  <= ch_audio;
            acc   <= '0;
            idx   <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (clk_3MHz_en) begin
            acc <= acc + term;
            idx <= idx + 1'b1;
            if (idx == IDX_W'(NUM_CH - 1)) state <= ST_SAT;
          end
        end
        ST_SAT: begin
          result <= (acc_ext > OUT_MAX) ? '1 : OUT_W'(acc_ext);
          state  <= ST_OUT;
        end
        ST_OUT: begin
          audio       <= out_next;
          audio_valid <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
